// File: rtl/xbar_pkg.sv
// Shared types and helpers for the xbar sorting-network slice.
//   batch_state_t : ingress batch assembler FSM states
//   popcount()    : count of set bits in the low 'width' bits of a vector
package xbar_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StIssue
    } batch_state_t;

    // Widest vector popcount() accepts; callers zero-extend into this width.
    localparam int unsigned PopcntMaxWidth = 1024;

    function automatic int unsigned popcount(input logic [PopcntMaxWidth-1:0] bits,
                                             input int unsigned width);
        int unsigned cnt;
        cnt = 0;
        for (int unsigned i = 0; i < PopcntMaxWidth; i++) begin
            if (i < width && bits[i]) cnt++;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/xbar_batch_issue_lane_slot.sv
// lane_slot: one lane's register slot in the batch assembler.
//   clk, n_rst     : clock, synchronous active-low reset
//   capture        : latch din/shift and mark the lane captured
//   clear          : drop the captured flag (batch accepted downstream)
//   pad            : load the max-value sentinel with the lane's own index as tag
//   din, shift     : incoming lane data and tag
//   q_din, q_shift : held lane data and tag (drive the batch outputs directly)
//   captured       : lane holds a real request
module lane_slot #(
    parameter int unsigned DWIDTH   = 16,
    parameter int unsigned TAGWIDTH = 5,
    parameter logic [TAGWIDTH-1:0] LANE = '0
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                capture,
    input  logic                clear,
    input  logic                pad,
    input  logic [DWIDTH-1:0]   din,
    input  logic [TAGWIDTH-1:0] shift,
    output logic [DWIDTH-1:0]   q_din,
    output logic [TAGWIDTH-1:0] q_shift,
    output logic                captured
);

    // capture/clear/pad are mutually exclusive by construction in the parent.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            q_din    <= '0;
            q_shift  <= '0;
            captured <= 1'b0;
        end else if (clear) begin
            captured <= 1'b0;
        end else if (capture) begin
            q_din    <= din;
            q_shift  <= shift;
            captured <= 1'b1;
        end else if (pad) begin
            q_din    <= '1;
            q_shift  <= LANE;
        end
    end

endmodule

// File: rtl/xbar_batch_issue.sv
// xbar_batch_issue: ingress batch assembler ahead of the bitonic sorting network.
// Collects up to SIZE lane requests, pads empty lanes with all-ones sentinels and
// presents a registered batch with one out_valid/out_ready handshake.
//   clk, n_rst                : clock, synchronous active-low reset
//   in_valid/in_ready         : per-lane request handshake
//   in_din/in_shift           : per-lane sort key and shift tag
//   flush                     : issue the current partial batch (ignored when idle)
//   out_valid/out_ready       : batch handshake toward the network
//   out_din/out_shift         : lane-indexed batch data and tags
//   out_count                 : number of real (non-pad) lanes in the batch
//   busy                      : assembler not idle
module xbar_batch_issue
    import xbar_pkg::*;
#(
    parameter int unsigned SIZE     = 32,
    parameter int unsigned DWIDTH   = 16,
    parameter int unsigned TIMEOUT  = 8,
    localparam int unsigned TAGWIDTH = $clog2(SIZE)
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic [SIZE-1:0]                in_valid,
    input  logic [SIZE-1:0][DWIDTH-1:0]    in_din,
    input  logic [SIZE-1:0][TAGWIDTH-1:0]  in_shift,
    output logic [SIZE-1:0]                in_ready,
    input  logic                           flush,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [SIZE-1:0][DWIDTH-1:0]    out_din,
    output logic [SIZE-1:0][TAGWIDTH-1:0]  out_shift,
    output logic [TAGWIDTH:0]              out_count,
    output logic                           busy
);

    localparam int unsigned TimerW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    batch_state_t                state_q;
    logic [TimerW-1:0]           timer_q;
    logic [SIZE-1:0]             captured_q;
    logic [SIZE-1:0]             cap_fire;
    logic [SIZE-1:0]             captured_nx;
    logic [PopcntMaxWidth-1:0]   pc_in;
    logic [TAGWIDTH:0]           count_nx;
    logic                        all_full;
    logic                        timeout_hit;
    logic                        issue_go;
    logic                        accept;

    assign in_ready = (state_q != StIssue) ? ~captured_q : '0;
    assign busy     = (state_q != StIdle);

    always_comb begin
        cap_fire    = in_valid & in_ready;
        // Captures at the issuing edge belong to the batch being issued.
        captured_nx = captured_q | cap_fire;
        all_full    = &captured_nx;
        timeout_hit = (timer_q == TimerW'(TIMEOUT - 1));
        issue_go    = 1'b0;
        unique case (state_q)
            StIdle:    issue_go = all_full;
            StCollect: issue_go = all_full || timeout_hit || flush;
            default:   issue_go = 1'b0;
        endcase
        accept      = (state_q == StIssue) && out_ready;
        pc_in       = '0;
        pc_in[SIZE-1:0] = captured_nx;
        count_nx    = (TAGWIDTH + 1)'(popcount(pc_in, SIZE));
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            out_valid <= 1'b0;
            out_count <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (issue_go) begin
                        state_q   <= StIssue;
                        out_valid <= 1'b1;
                        out_count <= count_nx;
                        timer_q   <= '0;
                    end else if (|cap_fire) begin
                        state_q <= StCollect;
                        timer_q <= '0;
                    end
                end
                StCollect: begin
                    if (issue_go) begin
                        state_q   <= StIssue;
                        out_valid <= 1'b1;
                        out_count <= count_nx;
                        timer_q   <= '0;
                    end else begin
                        timer_q <= timer_q + TimerW'(1);
                    end
                end
                StIssue: begin
                    if (out_ready) begin
                        state_q   <= StIdle;
                        out_valid <= 1'b0;
                        timer_q   <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    for (genvar i = 0; i < SIZE; i++) begin : g_slot
        lane_slot #(
            .DWIDTH   (DWIDTH),
            .TAGWIDTH (TAGWIDTH),
            .LANE     (TAGWIDTH'(i))
        ) u_slot (
            .clk      (clk),
            .n_rst    (n_rst),
            .capture  (cap_fire[i]),
            .clear    (accept),
            .pad      (issue_go && !captured_nx[i]),
            .din      (in_din[i]),
            .shift    (in_shift[i]),
            .q_din    (out_din[i]),
            .q_shift  (out_shift[i]),
            .captured (captured_q[i])
        );
    end

endmodule

// File: doc/xbar_batch_issue.md
# xbar_batch_issue

Ingress batch assembler that sits directly upstream of the xbar bitonic sorting network. It collects up to SIZE per-lane requests (data value plus shift tag) through per-lane valid/ready handshakes. It pads any unfilled lanes with max-value sentinels and presents a stable, registered batch to the network with a single out_valid/out_ready handshake. A batch issues when all lanes are filled, when a timeout expires, or when flush is asserted.

## Interface
- SIZE, 32, number of lanes; power of two, ≥2
- DWIDTH, 16, data width per lane
- TIMEOUT, 8, cycles to wait after the first capture before issuing a partial batch; ≥1
- TAGWIDTH (local), $clog2(SIZE), shift tag width

- clk  in  1  clock; all state updates on the rising edge
- n_rst  in  1  reset, synchronous and active-low
- in_valid  in  [SIZE]  lane request valid
- in_din  in  [SIZE][DWIDTH]  lane data (sort key)
- in_shift  in  [SIZE][TAGWIDTH]  lane shift tag
- in_ready  out  [SIZE]  lane can accept
- flush  in  1  force issue of the current partial batch
- out_valid  out  1  batch presented to the network
- out_ready  in  1  network accepts batch
- out_din  out  [SIZE][DWIDTH]  batch data, lane-indexed
- out_shift  out  [SIZE][TAGWIDTH]  batch tags
- out_count  out  TAGWIDTH+1  number of real (non-pad) lanes in the batch
- busy  out  1  state ≠ IDLE

## Operation
- **State machine:** IDLE, COLLECT, ISSUE.
- **Lane capture:** in_ready[i] = (state ≠ ISSUE) && !captured[i]. When in_valid[i] && in_ready[i] at an edge:
  - latch din and shift into lane i;
  - set captured[i].
- **Lane positions:** a lane keeps its own index position. There is no compaction.
- **IDLE:**
  - If any lane is captured this edge → COLLECT, timer←0.
  - If every lane is captured at the same edge → ISSUE directly.
  - flush in IDLE is ignored.
- **COLLECT:**
  - timer increments each edge.
  - → ISSUE at the edge where any of the following holds:
    - all SIZE lanes are captured, counting captures made at that same edge;
    - timer == TIMEOUT-1;
    - flush == 1.
  - Captures at the transition edge are included in the batch.
- **Entering ISSUE:**
  - Each uncaptured lane i is loaded with din = all ones and shift = i.
  - out_count = popcount(captured) after that edge's captures.
- **ISSUE:**
  - out_valid = 1.
  - out_din, out_shift and out_count hold stable until out_ready.
  - On an edge with out_ready: clear all captured bits, timer←0, → IDLE.
  - No lane captures while in ISSUE.
- **Pad ordering:** pads are the maximum value, so after the ascending sort they occupy the top SIZE-out_count positions. A real entry equal to all ones is indistinguishable from a pad by value, so downstream uses out_count.

## Timing
- **Reset values:**
  - state IDLE; captured, timer, out_din, out_shift and out_count all 0;
  - out_valid 0; busy 0;
  - in_ready all 1 in the first cycle after reset.
- **Reset mid-operation:** synchronous reset discards any partial or pending batch. No out_valid follows.
- **Capture to in_ready:** in_ready[i] drops the cycle after lane i's capture edge.
- **Timeout issue:** with a first capture at edge E0, out_valid rises after edge E0+TIMEOUT (TIMEOUT=1 → after edge E0+1).
- **Full issue:** the full condition issues at the edge of the last capture, so out_valid is high in the next cycle.
- **Flush:** flush sampled high in COLLECT gives out_valid in the following cycle.
- **Back-to-back batches:** out_ready accepted at edge E → IDLE and in_ready all 1 in the cycle after E. New captures are possible at edge E+1, so there is one bubble cycle between batches.
- **Downstream stall:** out_ready low holds ISSUE indefinitely with outputs unchanged.
- **Simultaneous events:** at a COLLECT edge where full, timeout and flush coincide, the block issues once with all captures included.

## Structure
- **xbar_pkg additions:**
  - batch_state_t enum {IDLE, COLLECT, ISSUE};
  - popcount function parameterised on width.
- **Sub-module:** lane_slot, one register slot per lane holding din, shift and captured, with the capture/clear/pad controls. The top level holds the FSM, timer, popcount and the generate loop over SIZE slots.
- **Output registers:** the outputs are registered, so the network's first stage sees a stable batch for its whole combinational path.

## Test plan
Bench configuration: SIZE=4, DWIDTH=8, TIMEOUT=3.
- **Full batch in one cycle:** all 4 lanes valid with din {9,3,7,1} at one edge → out_valid next cycle, out_din {9,3,7,1}, out_count 4, in_ready 0 while out_ready is held low.
- **Timeout:** lane 2 captures din 5 at edge E0 → out_valid after edge E0+3, out_din {FF,FF,5,FF}, out_shift {0,1,tag,3}, out_count 1.
- **Flush:** lanes 0 and 1 captured, then flush one cycle later → out_valid the next cycle, out_count 2. Also assert flush in IDLE → no out_valid.
- **Stall and back-to-back:** hold out_ready low for 5 cycles → outputs stable, in_ready 0. Release → IDLE, and new captures at the following edge form a second batch.
- **Coincident events:** the last lane captured on the same edge timer hits TIMEOUT-1 while flush is high → exactly one issue, out_count 4.
- **Reset mid-operation:** n_rst low while in COLLECT with 2 lanes captured → all outputs at reset values the next cycle, no issue afterward.
